// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a little-endian byte stream
// (4-byte word count header, then N words) into sequential imem writes.
module imem_loader #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          start,
    output logic          we,
    output logic [AW-1:0] wa,
    output logic [31:0]   wd,
    output logic          done,
    output logic          err,
    output logic          cpu_reset_n
);

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [31:0] word_idx;
    logic [31:0] n;
    logic [31:0] wbuf;
    logic [31:0] n_asm;
    logic [31:0] w_asm;
    logic        xfer;
    logic        last_byte;

    assign xfer      = in_valid && in_ready;
    assign last_byte = (byte_idx == 2'd3);

    // Header / word value including the byte arriving this cycle
    always_comb begin
        n_asm = n;
        w_asm = wbuf;
        n_asm[{byte_idx, 3'b000} +: 8] = in_data;
        w_asm[{byte_idx, 3'b000} +: 8] = in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= HDR;
            byte_idx    <= 2'd0;
            word_idx    <= 32'd0;
            n           <= 32'd0;
            wbuf        <= 32'd0;
            in_ready    <= 1'b1;
            we          <= 1'b0;
            wa          <= '0;
            wd          <= 32'd0;
            done        <= 1'b0;
            err         <= 1'b0;
            cpu_reset_n <= 1'b0;
        end else begin
            we <= 1'b0;
            case (state)
                HDR: begin
                    if (xfer) begin
                        n        <= n_asm;
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            word_idx <= 32'd0;
                            if (n_asm == 32'd0) begin
                                state       <= DONE;
                                done        <= 1'b1;
                                cpu_reset_n <= 1'b1;
                                in_ready    <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        wbuf     <= w_asm;
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            // Words beyond the memory are drained but flagged
                            if (word_idx < 32'(DEPTH)) begin
                                we <= 1'b1;
                                wa <= AW'({word_idx, 2'b00});
                                wd <= w_asm;
                            end else begin
                                err <= 1'b1;
                            end
                            word_idx <= word_idx + 32'd1;
                            if (word_idx + 32'd1 == n) begin
                                state       <= DONE;
                                done        <= 1'b1;
                                cpu_reset_n <= 1'b1;
                                in_ready    <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state       <= HDR;
                        done        <= 1'b0;
                        err         <= 1'b0;
                        word_idx    <= 32'd0;
                        byte_idx    <= 2'd0;
                        n           <= 32'd0;
                        cpu_reset_n <= 1'b0;
                        in_ready    <= 1'b1;
                    end
                end
                default: begin
                    state <= HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader; expected writes come from the
// image format itself (word k of min(N,DEPTH) lands at byte address 4k).
module tb_imem_loader;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          start;
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic          done;
    logic          err;
    logic          cpu_reset_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] obs_wa[$];
    logic [31:0] obs_wd[$];
    logic        obs_dn[$];
    logic        obs_cr[$];

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .start      (start),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .done       (done),
        .err        (err),
        .cpu_reset_n(cpu_reset_n)
    );

    always #5 clk = ~clk;

    // Record every write pulse together with the status seen in that cycle
    always @(negedge clk) begin
        if (reset && we) begin
            obs_wa.push_back(wa);
            obs_wd.push_back(wd);
            obs_dn.push_back(done);
            obs_cr.push_back(cpu_reset_n);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        obs_wa.delete();
        obs_wd.delete();
        obs_dn.delete();
        obs_cr.delete();
    endtask

    // Idle cycles with garbage data; start pulses here must be ignored
    task automatic idle(input int cycles, input bit rand_start);
        repeat (cycles) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = rand_start ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        in_valid = 1'b1;
        in_data  = b;
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // gap_mode: 0 = full rate, 1 = random 0..2 idle cycles, 2 = two idle cycles
    task automatic gap(input int gap_mode);
        if (gap_mode == 1) idle($urandom_range(0, 2), 1'b1);
        else if (gap_mode == 2) idle(2, 1'b0);
    endtask

    task automatic run_load(input logic [31:0] n, input logic [31:0] words[$],
                            input int gap_mode, input string tag);
        int m;
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            if (i != 0) gap(gap_mode);
            send(8'(n >> (8 * i)), {tag, "_hdr"});
        end
        for (int k = 0; k < int'(n); k++) begin
            for (int j = 0; j < 4; j++) begin
                gap(gap_mode);
                send(8'(words[k] >> (8 * j)), {tag, "_dat"});
            end
            check({tag, "_err_run"}, 64'(err), 64'(k >= int'(DEPTH)));
            if (k != int'(n) - 1) check({tag, "_done_run"}, 64'(done), 64'd0);
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_cpurst"}, 64'(cpu_reset_n), 64'd1);
        check({tag, "_rdy_done"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        check({tag, "_we_idle"}, 64'(we), 64'd0);
        m = (int'(n) < int'(DEPTH)) ? int'(n) : int'(DEPTH);
        check({tag, "_nwr"}, 64'(obs_wa.size()), 64'(m));
        for (int k = 0; k < m && k < obs_wa.size(); k++) begin
            check({tag, "_wa"}, 64'(obs_wa[k]), 64'(4 * k));
            check({tag, "_wd"}, 64'(obs_wd[k]), 64'(words[k]));
            check({tag, "_wr_done"}, 64'(obs_dn[k]), 64'(32'(k) == n - 32'd1));
            check({tag, "_wr_cpurst"}, 64'(obs_cr[k]), 64'(32'(k) == n - 32'd1));
        end
        check({tag, "_err"}, 64'(err), 64'(n > 32'(DEPTH)));
    endtask

    // Start pulse from DONE, optionally with a coincident byte that must be dropped
    task automatic do_start(input bit with_byte);
        check("start_pre_done", 64'(done), 64'd1);
        in_valid = with_byte;
        in_data  = 8'hFF;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("start_done", 64'(done), 64'd0);
        check("start_cpurst", 64'(cpu_reset_n), 64'd0);
        check("start_err", 64'(err), 64'd0);
        check("start_rdy", 64'(in_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 64'(we), 64'd0);
        check({tag, "_wa"}, 64'(wa), 64'd0);
        check({tag, "_wd"}, 64'(wd), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_cpurst"}, 64'(cpu_reset_n), 64'd0);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] n;

        reset    = 1'b0;
        in_data  = 8'd0;
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        @(negedge clk);
        check("rst_rdy", 64'(in_ready), 64'd1);

        q = {32'h00500013, 32'h00100093, 32'h00208133};
        run_load(32'd3, q, 0, "t1");
        do_start(1'b0);

        q = {};
        run_load(32'd0, q, 0, "t2");
        do_start(1'b0);

        q = {32'h11111111, 32'h22222222, 32'h33333333,
             32'h44444444, 32'h55555555, 32'h66666666};
        run_load(32'd6, q, 0, "t3");
        do_start(1'b0);

        q = {32'hA1B2C3D4, 32'h0F1E2D3C};
        run_load(32'd2, q, 2, "t4");
        do_start(1'b1);

        // Reset mid-load after two bytes of the second word
        clear_obs();
        send(8'h03, "t5_hdr");
        send(8'h00, "t5_hdr");
        send(8'h00, "t5_hdr");
        send(8'h00, "t5_hdr");
        for (int i = 0; i < 6; i++) send(8'($urandom), "t5_dat");
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rdy", 64'(in_ready), 64'd1);
        check("t5_nwr_partial", 64'(obs_wa.size()), 64'd1);
        q = {32'hDEADBEEF};
        run_load(32'd1, q, 0, "t5");
        do_start(1'b0);

        q = {32'h00000073};
        run_load(32'd1, q, 0, "t6");
        do_start(1'b1);

        for (int r = 0; r < 8; r++) begin
            n = 32'($urandom_range(0, 6));
            q = {};
            for (int k = 0; k < int'(n); k++) q.push_back($urandom);
            run_load(n, q, 1, "rnd");
            do_start(1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the single-cycle core's instruction memory.
- Receives a byte stream from a UART receiver or testbench over a valid/ready handshake.
- Assembles the bytes into little-endian 32-bit instruction words and writes them sequentially into the imem write port.
- Holds the core in reset until the program image is fully loaded.
- The core later reads the same words back through the existing imem read address port.

Parameters:
- DEPTH, 64, number of 32-bit words in the instruction memory (power of two, ≥4).
- AW, 32, width of the byte address driven on wa; matches the core's imem address width.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- start  in  1  single-cycle pulse; restarts loading from DONE.
- we  out  1  imem write enable, single-cycle pulse per word.
- wa  out  AW  imem byte address of the write; always word-aligned.
- wd  out  32  imem write data.
- done  out  1  image fully loaded.
- err  out  1  image longer than DEPTH; sticky until the next load.
- cpu_reset_n  out  1  core reset; low while loading, high only in DONE.

Behaviour:
- Byte transfer occurs on a rising clk edge when in_valid && in_ready.
- Image format:
  - 4-byte header holding word count N, little-endian, first byte = bits [7:0].
  - Followed by N words, each 4 bytes, little-endian.
- Reset (reset low, asynchronous), all outputs and state:
  - state=HDR, byte_idx=0, word_idx=0, N=0.
  - we=0, wa=0, wd=0, done=0, err=0, cpu_reset_n=0.
  - in_ready=1 once reset deasserts.
- FSM states:
  - HDR: in_ready=1. Each accepted byte fills N[8*byte_idx+:8]. On the 4th byte, byte_idx resets to 0. If the assembled N==0, go to DONE; else go to DATA with word_idx=0.
  - DATA: in_ready=1. Each accepted byte fills a word shift register at byte lane byte_idx.
    - On the 4th byte: if word_idx<DEPTH, the next cycle drives we=1, wa=word_idx*4, wd=assembled word.
    - If word_idx≥DEPTH, the word is discarded and err is set to 1.
    - word_idx increments. When the incremented word_idx==N, go to DONE; else stay in DATA.
  - DONE: in_ready=0, done=1, cpu_reset_n=1. A start pulse returns the FSM to HDR and clears done, err, word_idx, byte_idx and N. cpu_reset_n drops to 0 the cycle after start is sampled.
- Write timing:
  - Latency is exactly 1 cycle from the 4th byte's handshake edge to we=1.
  - we is high for exactly 1 cycle per stored word.
  - wa and wd hold their last values when we=0.
- Back-to-back bytes: full rate of 1 byte per cycle is supported. The write of word k overlaps acceptance of word k+1's first byte; no stall is needed.
- The final word's we pulse coincides with the first DONE cycle. cpu_reset_n rises in that same cycle; the core's first fetch then sees a completed write.
- in_valid gaps: state and byte_idx hold; no timeout.
- start while not in DONE: ignored.
- start coincident with a byte in DONE: the byte is not accepted (in_ready=0).
- wa wraps never: writes are suppressed once word_idx≥DEPTH. N up to 2^32-1 is accepted; excess words are drained and counted.
- Reset mid-load: asynchronous return to HDR. A partially assembled word is dropped and no write is issued. imem contents are not cleared.

Test Plan:
- Header 03 00 00 00, then bytes 13 00 50 00 / 93 00 10 00 / 33 81 20 00 at full rate → we pulses with wa=0,4,8 and wd=0x00500013, 0x00100093, 0x00208133; done=1 and cpu_reset_n=1 in the cycle of the third we.
- Header 00 00 00 00 → no we; done=1 the cycle after the 4th header byte; in_ready=0 thereafter.
- DEPTH=4, header N=6, six words → four writes at wa=0..12; err=1 after the 5th word; all 24 data bytes accepted; done=1, err still 1.
- N=2 with in_valid toggled 1-0-0-1 between bytes → same wa/wd as the gap-free case; no spurious we.
- Assert reset low after 2 bytes of word 1 (N=3) → all outputs return to reset values immediately; reload with N=1, word 0xDEADBEEF → single write wa=0, wd=0xDEADBEEF.
- In DONE, pulse start, then send N=1, word 0x00000073 → done drops, cpu_reset_n=0 next cycle; write at wa=0; done=1 again.
